load_store_unit: RTL and testbench

//   CPU-side initiator for data-memory accesses. Accepts one load/store from execute stage,

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_lane_align.sv | 54 +++++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helper functions for the load/store unit: funct3 access
// types, FSM states, access size and legality decoding.
package lsu_pkg;

    typedef enum logic [2:0] {
        MT_B  = 3'b000,
        MT_H  = 3'b001,
        MT_W  = 3'b010,
        MT_BU = 3'b100,
        MT_HU = 3'b101
    } mem_type_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RSP   = 3'd5
    } lsu_state_e;

    // Access size in bytes; 0 for encodings that are not a load/store type.
    function automatic logic [2:0] size_of(input logic [2:0] t);
        case (t)
            MT_B, MT_BU: size_of = 3'd1;
            MT_H, MT_HU: size_of = 3'd2;
            MT_W:        size_of = 3'd4;
            default:     size_of = 3'd0;
        endcase
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic is_legal(input logic [2:0] t, input logic we);
        case (t)
            MT_B, MT_H, MT_W: is_legal = 1'b1;
            MT_BU, MT_HU:     is_legal = !we;
            default:          is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] size);
        crosses_word = ({1'b0, off} + size) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and write data for each beat,
// plus shift and sign/zero extension of returned load data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_type,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata0,
    input  logic [31:0] i_rdata1,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wdata0,
    output logic [31:0] o_wdata1,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_sh;
    logic [7:0]  w_mask;
    logic [7:0]  w_be;
    logic [31:0] w_word;

    assign w_sh = {i_off, 3'b000};

    always_comb begin
        case (size_of(i_type))
            3'd1:    w_mask = 8'h01;
            3'd2:    w_mask = 8'h03;
            3'd4:    w_mask = 8'h0F;
            default: w_mask = 8'h00;
        endcase
    end

    // Lanes spilling past byte 3 belong to the second beat.
    assign w_be  = w_mask << i_off;
    assign o_be0 = w_be[3:0];
    assign o_be1 = w_be[7:4];

    assign o_wdata0 = i_wdata << w_sh;
    assign o_wdata1 = (i_wdata << w_sh) | (i_wdata >> (6'd32 - {1'b0, w_sh}));

    assign w_word = 32'({i_rdata1, i_rdata0} >> w_sh);

    always_comb begin
        case (i_type)
            MT_B:    o_rdata = {{24{w_word[7]}}, w_word[7:0]};
            MT_H:    o_rdata = {{16{w_word[15]}}, w_word[15:0]};
            MT_BU:   o_rdata = {24'h000000, w_word[7:0]};
            MT_HU:   o_rdata = {16'h0000, w_word[15:0]};
            default: o_rdata = w_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU access into word beats on the memory bus and
// returns aligned load data. Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [31:0]       cpu_req_addr,
    input  logic              cpu_req_we,
    input  logic [2:0]        cpu_req_type,
    input  logic [31:0]       cpu_req_wdata,
    output logic              cpu_rsp_valid,
    output logic [31:0]       cpu_rsp_rdata,
    output logic              cpu_rsp_fault,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [3:0]        mem_req_be,
    output logic [31:0]       mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic [ADDR_W+1:0] r_addr;
    logic              r_we;
    logic [2:0]        r_type;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rd0;
    logic [31:0]       r_rd1;
    logic              r_fault;
    logic              r_split;

    logic              w_accept;
    logic              w_cross;
    logic              w_fault_in;
    logic              w_split_in;
    logic [ADDR_W-1:0] w_waddr0;
    logic [ADDR_W-1:0] w_waddr1;
    logic [3:0]        w_be0;
    logic [3:0]        w_be1;
    logic [31:0]       w_wd0;
    logic [31:0]       w_wd1;
    logic [31:0]       w_load;
    logic              w_unused_addr;

    assign w_unused_addr = ^cpu_req_addr[31:ADDR_W+2];

    assign cpu_req_ready = (r_state == S_IDLE);
    assign w_accept      = cpu_req_valid && cpu_req_ready;
    assign w_cross       = crosses_word(cpu_req_addr[1:0], size_of(cpu_req_type));

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_split_in = w_cross;
    assign w_fault_in = !is_legal(cpu_req_type, cpu_req_we);
`else
    assign w_split_in = 1'b0;
    assign w_fault_in = !is_legal(cpu_req_type, cpu_req_we) || w_cross;
`endif

    // Second beat address wraps naturally at the top of the word space.
    assign w_waddr0 = r_addr[ADDR_W+1:2];
    assign w_waddr1 = w_waddr0 + ADDR_W'(1);

    lsu_lane_align u_align (
        .i_off    (r_addr[1:0]),
        .i_type   (r_type),
        .i_wdata  (r_wdata),
        .i_rdata0 (r_rd0),
        .i_rdata1 (r_rd1),
        .o_be0    (w_be0),
        .o_be1    (w_be1),
        .o_wdata0 (w_wd0),
        .o_wdata1 (w_wd1),
        .o_rdata  (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
            r_split <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_fault <= w_fault_in;
                r_split <= w_split_in;
            end
        end
    end

    // Beat buffers clear on accept so a single-beat load sees zeros above beat 0.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= cpu_req_addr[ADDR_W+1:0];
            r_we    <= cpu_req_we;
            r_type  <= cpu_req_type;
            r_wdata <= cpu_req_wdata;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end
        if (r_state == S_WAIT0 && mem_rsp_valid) begin
            r_rd0 <= mem_rsp_rdata;
        end
        if (r_state == S_WAIT1 && mem_rsp_valid) begin
            r_rd1 <= mem_rsp_rdata;
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_we    = 1'b0;
        mem_req_be    = 4'h0;
        mem_req_wdata = 32'h0;
        cpu_rsp_valid = 1'b0;
        cpu_rsp_rdata = 32'h0;
        cpu_rsp_fault = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    w_next = w_fault_in ? S_RSP : S_REQ0;
                end
            end
            S_REQ0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = w_waddr0;
                mem_req_we    = r_we;
                mem_req_be    = w_be0;
                mem_req_wdata = w_wd0;
                if (mem_req_ready) begin
                    w_next = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (mem_rsp_valid) begin
                    w_next = r_split ? S_REQ1 : S_RSP;
                end
            end
            S_REQ1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = w_waddr1;
                mem_req_we    = r_we;
                mem_req_be    = w_be1;
                mem_req_wdata = w_wd1;
                if (mem_req_ready) begin
                    w_next = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_rsp_valid) begin
                    w_next = S_RSP;
                end
            end
            S_RSP: begin
                cpu_rsp_valid = 1'b1;
                cpu_rsp_fault = r_fault;
                cpu_rsp_rdata = (r_fault || r_we) ? 32'h0 : w_load;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected beats and
// responses; independent monitors compare whatever the DUT presents.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_we;
    logic [2:0]  cpu_req_type;
    logic [31:0] cpu_req_wdata;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic        cpu_rsp_fault;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_req_we;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
    } rsp_t;

    beat_t       exp_beats[$];
    rsp_t        exp_rsps[$];
    logic [31:0] rd_q[$];

    int n_tests      = 0;
    int n_fail       = 0;
    int n_rsp_seen   = 0;
    int n_beats_seen = 0;
    int rsp_delay    = 1;

    load_store_unit #(.ADDR_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_type  (cpu_req_type),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .cpu_rsp_fault (cpu_rsp_fault),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_be    (mem_req_be),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push_beat(input logic [15:0] a, input logic [3:0] be, input logic we,
                             input logic [31:0] wd);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd;
        exp_beats.push_back(b);
    endtask

    task automatic push_rsp(input string nm, input logic [31:0] rd, input logic f);
        rsp_t r;
        r.name = nm; r.rdata = rd; r.fault = f;
        exp_rsps.push_back(r);
    endtask

    // Memory request monitor.
    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready && !rst) begin
            beat_t b;
            n_beats_seen++;
            if (exp_beats.size() == 0) begin
                chk("unexpected_beat", {mem_req_addr, mem_req_be, mem_req_we, mem_req_wdata}, 64'h0);
                n_fail += (mem_req_addr == 0 && mem_req_be == 0 && mem_req_wdata == 0) ? 1 : 0;
            end else begin
                b = exp_beats.pop_front();
                chk("mem_beat", {11'h0, mem_req_addr, mem_req_be, mem_req_we, mem_req_wdata},
                    {11'h0, b.addr, b.be, b.we, b.wdata});
            end
        end
    end

    // CPU response monitor.
    always @(negedge clk) begin
        if (cpu_rsp_valid) begin
            rsp_t r;
            n_rsp_seen++;
            if (exp_rsps.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %h fault %b, required no response",
                         cpu_rsp_rdata, cpu_rsp_fault);
            end else begin
                r = exp_rsps.pop_front();
                chk(r.name, {31'h0, cpu_rsp_fault, cpu_rsp_rdata}, {31'h0, r.fault, r.rdata});
            end
        end
    end

    // Memory responder: answers each accepted beat rsp_delay cycles later.
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready && !rst) begin
                repeat (rsp_delay) @(posedge clk);
                #1;
                mem_rsp_valid = 1'b1;
                if (rd_q.size() > 0) mem_rsp_rdata = rd_q.pop_front();
                else mem_rsp_rdata = 32'h0;
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic we, input logic [2:0] t,
                        input logic [31:0] wd);
        int g = 0;
        @(posedge clk);
        #1;
        while (!cpu_req_ready && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!cpu_req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: cpu_req_ready %b, required 1", cpu_req_ready);
        end
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        cpu_req_we    = we;
        cpu_req_type  = t;
        cpu_req_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input int exp_lat);
        int base = n_rsp_seen;
        int cyc = 0;
        while (n_rsp_seen == base && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (n_rsp_seen == base) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no cpu_rsp_valid after %0d cycles", nm, cyc);
        end else if (exp_lat >= 0) begin
            chk({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int nr;
        rst           = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = 32'h0;
        cpu_req_we    = 1'b0;
        cpu_req_type  = 3'b000;
        cpu_req_wdata = 32'h0;
        mem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(cpu_req_ready), 64'h1);
        chk("reset_rsp", {cpu_rsp_valid, cpu_rsp_fault, cpu_rsp_rdata}, 64'h0);
        chk("reset_mem", {mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata}, 64'h0);

        // Stores.
        push_beat(16'h0040, 4'b1111, 1'b1, 32'hDEADBEEF);
        push_rsp("sw_0x100", 32'h0, 1'b0);
        send(32'h0000_0100, 1'b1, 3'b010, 32'hDEADBEEF);
        wait_rsp("sw_0x100", 3);

        push_beat(16'h0040, 4'b1000, 1'b1, 32'hA500_0000);
        push_rsp("sb_0x103", 32'h0, 1'b0);
        send(32'h0000_0103, 1'b1, 3'b000, 32'h0000_00A5);
        wait_rsp("sb_0x103", 3);

        // Loads with extension.
        push_beat(16'h0040, 4'b0100, 1'b0, 32'h0);
        rd_q.push_back(32'h1280_3456);
        push_rsp("lb_0x102", 32'hFFFF_FF80, 1'b0);
        send(32'h0000_0102, 1'b0, 3'b000, 32'h0);
        wait_rsp("lb_0x102", 3);

        push_beat(16'h0040, 4'b0100, 1'b0, 32'h0);
        rd_q.push_back(32'h1280_3456);
        push_rsp("lbu_0x102", 32'h0000_0080, 1'b0);
        send(32'h0000_0102, 1'b0, 3'b100, 32'h0);
        wait_rsp("lbu_0x102", -1);

        push_beat(16'h0040, 4'b1100, 1'b0, 32'h0);
        rd_q.push_back(32'h1280_3456);
        push_rsp("lhu_0x102", 32'h0000_1280, 1'b0);
        send(32'h0000_0102, 1'b0, 3'b101, 32'h0);
        wait_rsp("lhu_0x102", -1);

        push_beat(16'h0040, 4'b0110, 1'b0, 32'h0);
        rd_q.push_back(32'h00FE_DC00);
        push_rsp("lh_0x101", 32'hFFFF_FEDC, 1'b0);
        send(32'h0000_0101, 1'b0, 3'b001, 32'h0);
        wait_rsp("lh_0x101", -1);

        // Misaligned word load and halfword store across the top of memory.
        nb = n_beats_seen;
`ifdef LSU_MISALIGN_SPLIT_EN
        push_beat(16'h0040, 4'b1110, 1'b0, 32'h0);
        push_beat(16'h0041, 4'b0001, 1'b0, 32'h0);
        rd_q.push_back(32'h4433_2211);
        rd_q.push_back(32'h8877_6655);
        push_rsp("lw_0x101", 32'h5544_3322, 1'b0);
        send(32'h0000_0101, 1'b0, 3'b010, 32'h0);
        wait_rsp("lw_0x101", -1);
        chk("lw_0x101_beats", 64'(n_beats_seen - nb), 64'd2);

        push_beat(16'hFFFF, 4'b1000, 1'b1, 32'hEF00_0000);
        push_beat(16'h0000, 4'b0001, 1'b1, 32'hEF00_00BE);
        push_rsp("sh_wrap", 32'h0, 1'b0);
        send(32'h0003_FFFF, 1'b1, 3'b001, 32'h0000_BEEF);
        wait_rsp("sh_wrap", -1);
`else
        push_rsp("lw_0x101", 32'h0, 1'b1);
        send(32'h0000_0101, 1'b0, 3'b010, 32'h0);
        wait_rsp("lw_0x101", 1);
        chk("lw_0x101_no_beat", 64'(n_beats_seen), 64'(nb));

        push_rsp("sh_wrap", 32'h0, 1'b1);
        send(32'h0003_FFFF, 1'b1, 3'b001, 32'h0000_BEEF);
        wait_rsp("sh_wrap", 1);
        chk("sh_wrap_no_beat", 64'(n_beats_seen), 64'(nb));
`endif

        // Memory back-pressure: request must hold steady.
        mem_req_ready = 1'b0;
        push_beat(16'h0080, 4'b1111, 1'b1, 32'h1234_5678);
        push_rsp("sw_stall", 32'h0, 1'b0);
        send(32'h0000_0200, 1'b1, 3'b010, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_hold", {11'h0, mem_req_valid, mem_req_addr, mem_req_be, mem_req_we, mem_req_wdata},
                {11'h0, 1'b1, 16'h0080, 4'hF, 1'b1, 32'h1234_5678});
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        wait_rsp("sw_stall", -1);

        // Reset while waiting for the beat; the late answer must be dropped.
        rsp_delay = 3;
        push_beat(16'h00C0, 4'b1111, 1'b0, 32'h0);
        rd_q.push_back(32'hCAFE_F00D);
        nr = n_rsp_seen;
        send(32'h0000_0300, 1'b0, 3'b010, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 64'(cpu_req_ready), 64'h1);
        chk("rst_mid_mem_idle", 64'(mem_req_valid), 64'h0);
        repeat (6) @(negedge clk);
        #1;
        chk("rst_mid_no_rsp", 64'(n_rsp_seen), 64'(nr));
        rsp_delay = 1;

        push_beat(16'h0041, 4'b1111, 1'b0, 32'h0);
        rd_q.push_back(32'h0BAD_F00D);
        push_rsp("lw_after_rst", 32'h0BAD_F00D, 1'b0);
        send(32'h0000_0104, 1'b0, 3'b010, 32'h0);
        wait_rsp("lw_after_rst", 3);

        // Illegal encodings fault without touching memory.
        nb = n_beats_seen;
        push_rsp("type_011", 32'h0, 1'b1);
        send(32'h0000_0100, 1'b0, 3'b011, 32'h0);
        wait_rsp("type_011", 1);

        push_rsp("sb_type_100", 32'h0, 1'b1);
        send(32'h0000_0100, 1'b1, 3'b100, 32'h0000_00FF);
        wait_rsp("sb_type_100", 1);

        push_rsp("type_111", 32'h0, 1'b1);
        send(32'h0000_0104, 1'b0, 3'b111, 32'h0);
        wait_rsp("type_111", -1);
        chk("fault_no_beat", 64'(n_beats_seen), 64'(nb));

        repeat (3) @(negedge clk);
        chk("beats_drained", 64'(exp_beats.size()), 64'd0);
        chk("rsps_drained", 64'(exp_rsps.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
